uart_tx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/uart_tx_fifo.sv | 176 +++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared encodings and helpers for the UART transmitter
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - synchronous FIFO with registered storage and head-word read port
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int PTR_W = clog2(DEPTH),
  localparam int LVL_W = clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push;
  logic             do_pop;

  assign full    = (level_q == LVL_W'(DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter with TX FIFO, selectable parity and stop bits
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 8,
  localparam int LVL_W = clog2(FIFO_DEPTH) + 1
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 sample_tick,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 tx_ready,
  input  logic [1:0]           parity_mode,
  input  logic                 two_stop,
  output logic                 tx_busy,
  output logic [LVL_W-1:0]     fifo_level,
  output logic                 tx_done,
  output logic                 tx_data
);

  localparam int TICK_W = clog2(2 * OVERSAMPLE);
  localparam int IDX_W  = clog2(DATA_BITS);
  localparam logic [TICK_W-1:0] BIT_LAST   = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] STOP2_LAST = TICK_W'(2 * OVERSAMPLE - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(DATA_BITS - 1);

  tx_state_e            state_q, state_d;
  logic [TICK_W-1:0]    tick_q, tick_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [1:0]           par_mode_q, par_mode_d;
  logic                 par_bit_q, par_bit_d;
  logic                 two_stop_q, two_stop_d;
  logic                 tx_data_q, tx_data_d;
  logic                 tx_done_q, tx_done_d;

  logic                 load;
  logic                 push;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_rd_data;
  logic                 bit_end;
  logic                 stop_end;

  assign tx_ready = !fifo_full;
  assign push     = tx_valid && tx_ready;
  assign tx_busy  = (state_q != ST_IDLE);
  assign tx_data  = tx_data_q;
  assign tx_done  = tx_done_q;
  assign bit_end  = sample_tick && (tick_q == BIT_LAST);
  assign stop_end = sample_tick && (tick_q == (two_stop_q ? STOP2_LAST : BIT_LAST));

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RESET),
    .push    (push),
    .wr_data (data_in),
    .pop     (load),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    par_mode_d = par_mode_q;
    par_bit_d  = par_bit_q;
    two_stop_d = two_stop_q;
    tx_data_d  = tx_data_q;
    tx_done_d  = 1'b0;
    load       = 1'b0;

    if (state_q != ST_IDLE && sample_tick) tick_d = tick_q + TICK_W'(1);

    case (state_q)
      ST_IDLE: load = !fifo_empty;
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          tick_d    = '0;
          bit_idx_d = '0;
          tx_data_d = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          tick_d = '0;
          if (bit_idx_q == IDX_LAST) begin
            if (par_mode_q != PAR_NONE) begin
              state_d   = ST_PARITY;
              tx_data_d = par_bit_q;
            end else begin
              state_d   = ST_STOP;
              tx_data_d = 1'b1;
            end
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
            shift_d   = shift_q >> 1;
            tx_data_d = shift_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d   = ST_STOP;
          tick_d    = '0;
          tx_data_d = 1'b1;
        end
      end
      ST_STOP: begin
        // The stop counter spans both stop bits so the frame ends in one place.
        if (stop_end) begin
          tx_done_d = 1'b1;
          tick_d    = '0;
          if (fifo_empty) begin
            state_d   = ST_IDLE;
            tx_data_d = 1'b1;
          end else begin
            load = 1'b1;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        tx_data_d = 1'b1;
      end
    endcase

    // Frame load: config and parity are frozen from the popped word.
    if (load) begin
      state_d    = ST_START;
      tick_d     = '0;
      bit_idx_d  = '0;
      shift_d    = fifo_rd_data;
      par_mode_d = (parity_mode == PAR_EVEN || parity_mode == PAR_ODD) ? parity_mode : PAR_NONE;
      par_bit_d  = (^fifo_rd_data) ^ (parity_mode == PAR_ODD);
      two_stop_d = two_stop;
      tx_data_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      tick_q     <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      par_mode_q <= PAR_NONE;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      tx_data_q  <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      par_mode_q <= par_mode_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
      tx_data_q  <= tx_data_d;
      tx_done_q  <= tx_done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo against a frame-level model
module tb_uart_tx_fifo;

  localparam int DB    = 8;
  localparam int OS    = 16;
  localparam int DEPTH = 4;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       sample_tick;
  logic       tx_valid;
  logic [7:0] data_in;
  logic       tx_ready;
  logic [1:0] parity_mode;
  logic       two_stop;
  logic       tx_busy;
  logic [2:0] fifo_level;
  logic       tx_done;
  logic       tx_data;

  int   n_pass;
  int   n_total;
  logic [7:0] exp_q[$];
  logic       line_q[$];

  always #5 CLK = ~CLK;

  uart_tx_fifo #(
    .DATA_BITS  (DB),
    .OVERSAMPLE (OS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .sample_tick (sample_tick),
    .tx_valid    (tx_valid),
    .data_in     (data_in),
    .tx_ready    (tx_ready),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .tx_busy     (tx_busy),
    .fifo_level  (fifo_level),
    .tx_done     (tx_done),
    .tx_data     (tx_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Expected line level for each bit period of one frame.
  task automatic build_frame(input logic [7:0] d, input logic [1:0] m, input logic ts);
    line_q.delete();
    line_q.push_back(1'b0);
    for (int i = 0; i < DB; i++) line_q.push_back(d[i]);
    if (m == 2'b01) line_q.push_back(($countones(d) % 2) == 1);
    else if (m == 2'b10) line_q.push_back(($countones(d) % 2) == 0);
    line_q.push_back(1'b1);
    if (ts) line_q.push_back(1'b1);
  endtask

  // Entered just after the edge that started the frame; returns just after the edge that ends it.
  task automatic run_frame(input int pct, input int toggle_bit, input logic [1:0] toggle_mode);
    logic [7:0] d;
    logic [1:0] m;
    logic       ts, ok_bit, seen, tk, done_bad, busy_bad;
    int         cycles, cnt;
    d  = exp_q.pop_front();
    m  = parity_mode;
    ts = two_stop;
    chk($sformatf("frame %02h start level", d), fifo_level, exp_q.size());
    build_frame(d, m, ts);
    cycles   = 0;
    done_bad = 1'b0;
    busy_bad = 1'b0;
    for (int b = 0; b < line_q.size(); b++) begin
      cnt    = 0;
      ok_bit = 1'b1;
      seen   = line_q[b];
      if (b == toggle_bit) parity_mode = toggle_mode;
      while (cnt < OS && cycles < 20000) begin
        if (ok_bit && tx_data !== line_q[b]) begin
          ok_bit = 1'b0;
          seen   = tx_data;
        end
        if (cycles > 0 && tx_done !== 1'b0) done_bad = 1'b1;
        if (tx_busy !== 1'b1) busy_bad = 1'b1;
        tk = (pct >= 100) ? 1'b1 : ($urandom_range(99) < pct);
        sample_tick = tk;
        step();
        cycles++;
        if (tk) cnt++;
      end
      chk($sformatf("frame %02h bit%0d line", d, b), seen, line_q[b]);
    end
    chk($sformatf("frame %02h timeout", d), cycles < 20000, 1);
    chk($sformatf("frame %02h done pulse", d), tx_done, 1);
    chk($sformatf("frame %02h early done", d), done_bad, 0);
    chk($sformatf("frame %02h busy drop", d), busy_bad, 0);
    if (pct >= 100) chk($sformatf("frame %02h cycles", d), cycles, OS * line_q.size());
  endtask

  task automatic push_into_empty(input logic [7:0] d);
    chk("push ready", tx_ready, 1);
    tx_valid = 1'b1;
    data_in  = d;
    step();
    tx_valid = 1'b0;
    exp_q.push_back(d);
    chk("push level", fifo_level, 1);
    chk("no fallthrough busy", tx_busy, 0);
    chk("no fallthrough line", tx_data, 1);
    step();
    chk("start busy", tx_busy, 1);
    chk("start line", tx_data, 0);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " busy"}, tx_busy, 0);
    chk({tag, " line"}, tx_data, 1);
    chk({tag, " level"}, fifo_level, 0);
  endtask

  initial begin
    logic [7:0] b;
    logic       exp_ready, bad;
    int         nf, pct;
    n_pass      = 0;
    n_total     = 0;
    RESET       = 1'b1;
    sample_tick = 1'b0;
    tx_valid    = 1'b0;
    data_in     = '0;
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    step();
    step();
    chk("rst tx_data", tx_data, 1);
    chk("rst tx_done", tx_done, 0);
    chk("rst tx_busy", tx_busy, 0);
    chk("rst level", fifo_level, 0);
    chk("rst ready", tx_ready, 1);
    RESET       = 1'b0;
    sample_tick = 1'b1;
    step();

    // 8N1 with 0x55
    push_into_empty(8'h55);
    run_frame(100, -1, 2'b00);
    chk_idle("8n1 idle");

    // 8E1 parity 1 and 0
    parity_mode = 2'b01;
    push_into_empty(8'h07);
    run_frame(100, -1, 2'b00);
    push_into_empty(8'h03);
    run_frame(100, -1, 2'b00);
    chk_idle("8e1 idle");

    // 8O2 with 0x00
    parity_mode = 2'b10;
    two_stop    = 1'b1;
    push_into_empty(8'h00);
    run_frame(100, -1, 2'b00);
    chk_idle("8o2 idle");

    // Push coinciding with the idle pop keeps the level
    parity_mode = 2'b00;
    two_stop    = 1'b0;
    tx_valid    = 1'b1;
    data_in     = 8'hC3;
    step();
    exp_q.push_back(8'hC3);
    data_in = 8'h3C;
    step();
    tx_valid = 1'b0;
    exp_q.push_back(8'h3C);
    chk("push+pop busy", tx_busy, 1);
    run_frame(100, -1, 2'b00);
    run_frame(100, -1, 2'b00);
    chk_idle("push+pop idle");

    // Fill to depth while the first frame holds in START
    sample_tick = 1'b0;
    push_into_empty(8'h81);
    for (int k = 0; k < 6; k++) begin
      b         = 8'($urandom);
      exp_ready = (exp_q.size() - 1) < DEPTH;
      chk($sformatf("fill%0d ready", k), tx_ready, exp_ready);
      tx_valid = 1'b1;
      data_in  = b;
      step();
      if (exp_ready) exp_q.push_back(b);
      chk($sformatf("fill%0d level", k), fifo_level, exp_q.size() - 1);
    end
    tx_valid = 1'b0;
    for (int k = 0; k < 5; k++) run_frame(100, -1, 2'b00);
    chk_idle("fill idle");

    // Parity enabled mid-frame applies only to the next frame
    sample_tick = 1'b0;
    push_into_empty(8'h5A);
    tx_valid = 1'b1;
    data_in  = 8'hB1;
    step();
    tx_valid = 1'b0;
    exp_q.push_back(8'hB1);
    run_frame(100, 3, 2'b01);
    run_frame(100, -1, 2'b00);
    chk_idle("toggle idle");

    // Reset during DATA with two bytes queued
    parity_mode = 2'b00;
    sample_tick = 1'b0;
    push_into_empty(8'hF0);
    tx_valid = 1'b1;
    data_in  = 8'h11;
    step();
    data_in = 8'h22;
    step();
    tx_valid = 1'b0;
    chk("pre-reset level", fifo_level, 2);
    sample_tick = 1'b1;
    for (int k = 0; k < 3 * OS + 5; k++) step();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    exp_q.delete();
    chk("mid rst line", tx_data, 1);
    chk("mid rst level", fifo_level, 0);
    chk("mid rst ready", tx_ready, 1);
    chk("mid rst done", tx_done, 0);
    chk("mid rst busy", tx_busy, 0);
    bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (tx_data !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) bad = 1'b1;
      step();
    end
    chk("post rst quiet", bad, 0);
    parity_mode = 2'b01;
    two_stop    = 1'b1;
    push_into_empty(8'hA5);
    run_frame(100, -1, 2'b00);
    chk_idle("post rst idle");

    // Randomized bursts with sparse ticks and random framing
    for (int it = 0; it < 8; it++) begin
      parity_mode = 2'($urandom_range(3));
      two_stop    = 1'($urandom_range(1));
      nf          = $urandom_range(1, 3);
      pct         = $urandom_range(30, 100);
      sample_tick = 1'b0;
      push_into_empty(8'($urandom));
      for (int k = 1; k < nf; k++) begin
        b        = 8'($urandom);
        tx_valid = 1'b1;
        data_in  = b;
        step();
        exp_q.push_back(b);
      end
      tx_valid = 1'b0;
      for (int k = 0; k < nf; k++) run_frame(pct, -1, 2'b00);
      chk_idle($sformatf("rand%0d idle", it));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
